// File: rtl/weight_load_sequencer.sv
// weight_load_sequencer: streams NUM = 4*WEIGHTS_PER_UNIT weights from the
// weight RAM into four processing units, unit 0 first. The write strobe and
// its unit/index tags are delayed by RAM_LAT cycles to line up with RAM data.
module weight_load_sequencer #(
  parameter int ADDR_W           = 8,
  parameter int WEIGHTS_PER_UNIT = 16,
  parameter int IDX_W            = 4,
  parameter int RAM_LAT          = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              ram_re,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [1:0]        unit_sel,
  output logic              write,
  output logic [IDX_W-1:0]  weight_idx,
  output logic              busy,
  output logic              done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WEIGHTS_PER_UNIT - 1);

  logic [1:0]        state;
  logic [ADDR_W-1:0] addr;
  logic [1:0]        unit;
  logic [IDX_W-1:0]  idx;
  logic              last_rd;
  logic              kill;

  // vld_pipe[0] holds the read issued last cycle; vld_pipe[RAM_LAT-1] is the write
  logic [RAM_LAT-1:0] vld_pipe;
  logic [1:0]         unit_pipe [RAM_LAT];
  logic [IDX_W-1:0]   idx_pipe  [RAM_LAT];

  assign last_rd = (unit == 2'd3) && (idx == IDX_LAST);
  // abort only acts once a transfer is under way
  assign kill    = abort && (state != S_IDLE);

  // FSM with read address and unit/index counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      addr  <= '0;
      unit  <= '0;
      idx   <= '0;
    end else if (kill) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (start && !abort) begin
          state <= S_RUN;
          addr  <= base_addr;
          unit  <= '0;
          idx   <= '0;
        end
        S_RUN: begin
          addr <= addr + ADDR_W'(1);  // wraps modulo 2**ADDR_W
          if (idx == IDX_LAST) begin
            idx  <= '0;
            unit <= unit + 2'd1;
          end else begin
            idx  <= idx + IDX_W'(1);
          end
          if (last_rd) state <= S_DRAIN;
        end
        // leave only once the last write has left the pipeline
        S_DRAIN: if (vld_pipe == '0) state <= S_DONE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // RAM_LAT-deep {valid, unit, idx} shift pipeline; abort flushes it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      for (int i = 0; i < RAM_LAT; i++) begin
        unit_pipe[i] <= '0;
        idx_pipe[i]  <= '0;
      end
    end else if (kill) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[0]  <= (state == S_RUN);
      unit_pipe[0] <= unit;
      idx_pipe[0]  <= idx;
      for (int i = 1; i < RAM_LAT; i++) begin
        vld_pipe[i]  <= vld_pipe[i-1];
        unit_pipe[i] <= unit_pipe[i-1];
        idx_pipe[i]  <= idx_pipe[i-1];
      end
    end
  end

  // Outputs decoded from registered state; tags forced to 0 when idle
  always_comb begin
    ram_re     = (state == S_RUN);
    ram_addr   = ram_re ? addr : '0;
    write      = vld_pipe[RAM_LAT-1];
    unit_sel   = write ? unit_pipe[RAM_LAT-1] : '0;
    weight_idx = write ? idx_pipe[RAM_LAT-1]  : '0;
    busy       = (state == S_RUN) || (state == S_DRAIN);
    done       = (state == S_DONE);
  end

endmodule

// File: tb/tb_weight_load_sequencer.sv
// Bench for weight_load_sequencer: two instances (RAM_LAT 1 and 3) share one
// stimulus stream; each has an event-timeline reference model and a monitor.
module tb_weight_load_sequencer;
  localparam int NUM = 64;
  localparam int WPU = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] base_addr = 8'h00;

  logic [1:0] ram_re, write, busy, done;
  logic [7:0] ram_addr   [2];
  logic [1:0] unit_sel   [2];
  logic [3:0] weight_idx [2];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  weight_load_sequencer #(.ADDR_W(8), .WEIGHTS_PER_UNIT(16), .IDX_W(4), .RAM_LAT(1)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .base_addr(base_addr),
    .ram_re(ram_re[0]), .ram_addr(ram_addr[0]), .unit_sel(unit_sel[0]), .write(write[0]),
    .weight_idx(weight_idx[0]), .busy(busy[0]), .done(done[0]));

  weight_load_sequencer #(.ADDR_W(8), .WEIGHTS_PER_UNIT(16), .IDX_W(4), .RAM_LAT(3)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .base_addr(base_addr),
    .ram_re(ram_re[1]), .ram_addr(ram_addr[1]), .unit_sel(unit_sel[1]), .write(write[1]),
    .weight_idx(weight_idx[1]), .busy(busy[1]), .done(done[1]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic flag(input string name, input int c);
    checks++;
    errors++;
    $display("FAIL %s: event at cycle %0d not matched at %0t", name, c, $time);
  endtask

  for (genvar g = 0; g < 2; g++) begin : chkr
    localparam int LAT = (g == 0) ? 1 : 3;
    int cyc = 0;
    bit have = 1'b0;
    int s = 0, busy_end = 0, idle_after = 0;
    int rd_c[$], rd_a[$], wr_c[$], wr_u[$], wr_i[$], dn_c[$];

    // Reference model: on an accepted start, schedule every read, write and
    // done event by cycle number; abort cancels everything not yet due.
    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        have = 1'b0;
        rd_c.delete(); rd_a.delete(); wr_c.delete(); wr_u.delete(); wr_i.delete(); dn_c.delete();
      end else begin
        cyc++;
        if (have && cyc > s && cyc <= idle_after) begin
          if (abort) begin
            while (rd_c.size() > 0 && rd_c[$] >= cyc) begin void'(rd_c.pop_back()); void'(rd_a.pop_back()); end
            while (wr_c.size() > 0 && wr_c[$] >= cyc) begin
              void'(wr_c.pop_back()); void'(wr_u.pop_back()); void'(wr_i.pop_back());
            end
            while (dn_c.size() > 0 && dn_c[$] >= cyc) void'(dn_c.pop_back());
            if (busy_end > cyc) busy_end = cyc;
            idle_after = cyc - 1;
          end
        end else if (start && !abort) begin
          have = 1'b1;
          s = cyc;
          busy_end = s + NUM + LAT + 1;
          idle_after = busy_end + 1;
          for (int n = 0; n < NUM; n++) begin
            rd_c.push_back(s + n);
            rd_a.push_back((int'(base_addr) + n) % 256);
            wr_c.push_back(s + n + LAT);
            wr_u.push_back(n / WPU);
            wr_i.push_back(n % WPU);
          end
          dn_c.push_back(busy_end);
        end
      end
    end

    // Monitor: pop the expected event whenever the DUT presents one
    always @(negedge clk) begin
      if (rst_n) begin
        while (rd_c.size() > 0 && rd_c[0] < cyc) begin flag("read_missing", rd_c[0]); void'(rd_c.pop_front()); void'(rd_a.pop_front()); end
        while (wr_c.size() > 0 && wr_c[0] < cyc) begin
          flag("write_missing", wr_c[0]); void'(wr_c.pop_front()); void'(wr_u.pop_front()); void'(wr_i.pop_front());
        end
        while (dn_c.size() > 0 && dn_c[0] < cyc) begin flag("done_missing", dn_c[0]); void'(dn_c.pop_front()); end

        if (ram_re[g]) begin
          if (rd_c.size() > 0 && rd_c[0] == cyc) begin
            chk($sformatf("ram_addr[lat%0d]", LAT), ram_addr[g], rd_a[0]);
            void'(rd_c.pop_front()); void'(rd_a.pop_front());
          end else flag($sformatf("ram_re_spurious[lat%0d]", LAT), cyc);
        end else chk($sformatf("ram_addr_idle[lat%0d]", LAT), ram_addr[g], 0);

        if (write[g]) begin
          if (wr_c.size() > 0 && wr_c[0] == cyc) begin
            chk($sformatf("unit_sel[lat%0d]", LAT), unit_sel[g], wr_u[0]);
            chk($sformatf("weight_idx[lat%0d]", LAT), weight_idx[g], wr_i[0]);
            void'(wr_c.pop_front()); void'(wr_u.pop_front()); void'(wr_i.pop_front());
          end else flag($sformatf("write_spurious[lat%0d]", LAT), cyc);
        end else begin
          chk($sformatf("unit_sel_idle[lat%0d]", LAT), unit_sel[g], 0);
          chk($sformatf("weight_idx_idle[lat%0d]", LAT), weight_idx[g], 0);
        end

        if (done[g]) begin
          if (dn_c.size() > 0 && dn_c[0] == cyc) begin
            checks++;
            void'(dn_c.pop_front());
          end else flag($sformatf("done_spurious[lat%0d]", LAT), cyc);
        end

        chk($sformatf("busy[lat%0d]", LAT), busy[g], (have && cyc >= s && cyc < busy_end) ? 1 : 0);
      end
    end
  end

  task automatic chk_zero(input string tag);
    for (int g = 0; g < 2; g++) begin
      chk({tag, "_ram_re"}, ram_re[g], 0);
      chk({tag, "_ram_addr"}, ram_addr[g], 0);
      chk({tag, "_write"}, write[g], 0);
      chk({tag, "_unit_sel"}, unit_sel[g], 0);
      chk({tag, "_weight_idx"}, weight_idx[g], 0);
      chk({tag, "_busy"}, busy[g], 0);
      chk({tag, "_done"}, done[g], 0);
    end
  endtask

  // One load: start pulse, optional abort in cycle start+abort_at, optional
  // stray start pulses, optional start one cycle after lat-1 done.
  task automatic load(input logic [7:0] b, input int abort_at, input bit repulse, input bit chain);
    @(negedge clk); base_addr = b; start = 1'b1;
    @(negedge clk); start = 1'b0; base_addr = 8'($urandom);
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      abort = (k == abort_at);
      start = 1'b0;
      if (k != abort_at) begin
        if (repulse && k <= 66 && ($urandom % 6 == 0)) start = 1'b1;
        if (repulse && k == 66) start = 1'b1;
        if (chain && k == 67) start = 1'b1;
      end
    end
    @(negedge clk); start = 1'b0; abort = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk_zero("idle");

    load(8'h10, 0, 1'b0, 1'b0);
    load(8'hF8, 0, 1'b0, 1'b0);
    load(8'h40, 20, 1'b0, 1'b0);
    load(8'h10, 0, 1'b0, 1'b0);
    load(8'h33, 0, 1'b1, 1'b1);
    repeat (80) @(negedge clk);
    load(8'h20, 76, 1'b0, 1'b0);
    for (int t = 0; t < 6; t++)
      load(8'($urandom), ($urandom % 2 == 1) ? int'($urandom_range(1, 72)) : 0, 1'b1, 1'b0);
    repeat (150) @(negedge clk);

    // asynchronous reset mid-transfer
    @(negedge clk); base_addr = 8'hA0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (30) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_zero("async_reset");
    @(negedge clk); rst_n = 1'b1;
    load(8'hE0, 0, 1'b0, 1'b0);
    repeat (80) @(negedge clk);

    chk("lat1_reads_left", chkr[0].rd_c.size(), 0);
    chk("lat1_writes_left", chkr[0].wr_c.size(), 0);
    chk("lat1_dones_left", chkr[0].dn_c.size(), 0);
    chk("lat3_reads_left", chkr[1].rd_c.size(), 0);
    chk("lat3_writes_left", chkr[1].wr_c.size(), 0);
    chk("lat3_dones_left", chkr[1].dn_c.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
